// File: rtl/telemetry_uart_tx.sv
// UART 8N1 transmitter for a fixed 16-byte telemetry frame:
// "M:SS DDDD VV F\r\n", where F is 'E' if times_up else 'R'.
module telemetry_uart_tx #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] mins,
   input  logic [6:0] tens,
   input  logic [6:0] ones,
   input  logic [6:0] distThousands,
   input  logic [6:0] distHundreds,
   input  logic [6:0] distTens,
   input  logic [6:0] distOnes,
   input  logic [6:0] speedTens,
   input  logic [6:0] speedOnes,
   input  logic       times_up,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_baud_check
         $fatal(1, "telemetry_uart_tx: CLK_HZ/BAUD must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [3:0]       byte_idx, byte_idx_n;
   logic             tx_n, busy_n, done_n;
   logic             load;
   logic [7:0]       cur_byte;

   logic [6:0] snap_mins, snap_tens, snap_ones;
   logic [6:0] snap_dth, snap_dhu, snap_dte, snap_don;
   logic [6:0] snap_ste, snap_son;
   logic       snap_times_up;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         tx       <= tx_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         snap_mins     <= '0;
         snap_tens     <= '0;
         snap_ones     <= '0;
         snap_dth      <= '0;
         snap_dhu      <= '0;
         snap_dte      <= '0;
         snap_don      <= '0;
         snap_ste      <= '0;
         snap_son      <= '0;
         snap_times_up <= 1'b0;
      end else if (load) begin
         snap_mins     <= mins;
         snap_tens     <= tens;
         snap_ones     <= ones;
         snap_dth      <= distThousands;
         snap_dhu      <= distHundreds;
         snap_dte      <= distTens;
         snap_don      <= distOnes;
         snap_ste      <= speedTens;
         snap_son      <= speedOnes;
         snap_times_up <= times_up;
      end
   end

   always_comb begin
      cur_byte = 8'h20;
      case (byte_idx)
         4'd0:  cur_byte = {1'b0, snap_mins};
         4'd1:  cur_byte = 8'h3A;
         4'd2:  cur_byte = {1'b0, snap_tens};
         4'd3:  cur_byte = {1'b0, snap_ones};
         4'd4:  cur_byte = 8'h20;
         4'd5:  cur_byte = {1'b0, snap_dth};
         4'd6:  cur_byte = {1'b0, snap_dhu};
         4'd7:  cur_byte = {1'b0, snap_dte};
         4'd8:  cur_byte = {1'b0, snap_don};
         4'd9:  cur_byte = 8'h20;
         4'd10: cur_byte = {1'b0, snap_ste};
         4'd11: cur_byte = {1'b0, snap_son};
         4'd12: cur_byte = 8'h20;
         4'd13: cur_byte = snap_times_up ? 8'h45 : 8'h52;
         4'd14: cur_byte = 8'h0D;
         4'd15: cur_byte = 8'h0A;
         default: cur_byte = 8'h20;
      endcase
   end

   // tx/busy/done are registered, so each branch computes the level for the
   // cycle after the transition edge; this keeps every bit exactly one baud long.
   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      tx_n       = tx;
      busy_n     = busy;
      done_n     = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            byte_idx_n = '0;
            tx_n       = 1'b1;
            busy_n     = 1'b0;
            if (start) begin
               load    = 1'b1;
               state_n = START_BIT;
               tx_n    = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START_BIT: begin
            if (baud_cnt == CNT_LAST) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = DATA_BITS;
               tx_n       = cur_byte[0];
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         DATA_BITS: begin
            if (baud_cnt == CNT_LAST) begin
               baud_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP_BIT;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
                  tx_n      = cur_byte[bit_idx_n];
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         STOP_BIT: begin
            if (baud_cnt == CNT_LAST) begin
               baud_cnt_n = '0;
               if (byte_idx == 4'd15) begin
                  state_n    = IDLE;
                  byte_idx_n = '0;
                  tx_n       = 1'b1;
                  busy_n     = 1'b0;
                  done_n     = 1'b1;
               end else begin
                  byte_idx_n = byte_idx + 1'b1;
                  state_n    = START_BIT;
                  tx_n       = 1'b0;
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Directed bench for telemetry_uart_tx at CLKS_PER_BIT = 10: decodes each
// frame cycle by cycle and compares against hand-written frame strings.
module tb_telemetry_uart_tx;

   logic       clk = 1'b0;
   logic       reset, start, times_up;
   logic [6:0] mins, tens, ones;
   logic [6:0] distThousands, distHundreds, distTens, distOnes;
   logic [6:0] speedTens, speedOnes;
   logic       tx, busy, done;

   always #5 clk = ~clk;

   telemetry_uart_tx #(.CLK_HZ(100), .BAUD(10)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mins(mins), .tens(tens), .ones(ones),
      .distThousands(distThousands), .distHundreds(distHundreds),
      .distTens(distTens), .distOnes(distOnes),
      .speedTens(speedTens), .speedOnes(speedOnes),
      .times_up(times_up), .tx(tx), .busy(busy), .done(done)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int hook_cyc = 0;
   int hook_act = 0;
   logic [7:0] rx [16];

   localparam string BASIC_IN  = "123004215";
   localparam string BASIC_OUT = "1:23 0042 15 R\r\n";
   localparam string NINE_OUT  = "9:99 9999 99 E\r\n";

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] ch7(input string s, input int i);
      logic [7:0] c;
      c = s[i];
      return c[6:0];
   endfunction

   task automatic set_inputs(input string s, input logic tu);
      mins          = ch7(s, 0);
      tens          = ch7(s, 1);
      ones          = ch7(s, 2);
      distThousands = ch7(s, 3);
      distHundreds  = ch7(s, 4);
      distTens      = ch7(s, 5);
      distOnes      = ch7(s, 6);
      speedTens     = ch7(s, 7);
      speedOnes     = ch7(s, 8);
      times_up      = tu;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Entered at cycle 1 of a frame (first cycle after the accept edge);
   // returns in cycle 1601, the expected done cycle.
   task automatic run_frame(input string tag, input string exp_str);
      int cyc;
      int timing_err, frame_err, busy_err, done_err;
      logic v;
      logic [7:0] e;
      cyc = 1; timing_err = 0; frame_err = 0; busy_err = 0; done_err = 0;
      v = 1'b0;
      for (int b = 0; b < 16; b++) begin
         for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 10; k++) begin
               if (k == 0) v = tx;
               else if (tx !== v) timing_err++;
               if (busy !== 1'b1) busy_err++;
               if (done !== 1'b0) done_err++;
               if (hook_act == 1 && cyc == hook_cyc) set_inputs("999999999", 1'b1);
               if (hook_act == 2 && cyc == hook_cyc) start = 1'b1;
               if (hook_act == 2 && cyc == hook_cyc + 1) start = 1'b0;
               if (hook_act == 3 && cyc == hook_cyc) start = 1'b0;
               tick();
               cyc++;
            end
            if (p == 0 && v !== 1'b0) frame_err++;
            else if (p == 9 && v !== 1'b1) frame_err++;
            else if (p >= 1 && p <= 8) rx[b][p-1] = v;
         end
      end
      for (int b = 0; b < 16; b++) begin
         e = exp_str[b];
         check($sformatf("%s_byte%0d", tag, b), {24'd0, rx[b]}, {24'd0, e});
      end
      check({tag, "_bit_timing"}, timing_err, 0);
      check({tag, "_framing"},    frame_err,  0);
      check({tag, "_busy"},       busy_err,   0);
      check({tag, "_early_done"}, done_err,   0);
      check({tag, "_done1601"},   {31'd0, done}, 1);
      check({tag, "_busy1601"},   {31'd0, busy}, 0);
      check({tag, "_tx1601"},     {31'd0, tx},   1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idle_err;
      reset = 1'b0;
      start = 1'b0;
      set_inputs(BASIC_IN, 1'b0);
      repeat (3) tick();
      check("rst_tx",   {31'd0, tx},   1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);

      reset = 1'b1;
      idle_err = 0;
      repeat (30) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_err++;
      end
      check("idle_quiet", idle_err, 0);

      start_frame();
      run_frame("basic", BASIC_OUT);
      tick();
      check("basic_done_width", {31'd0, done}, 0);

      hook_act = 1; hook_cyc = 50;
      start_frame();
      run_frame("snap", BASIC_OUT);
      hook_act = 0;
      tick();
      start_frame();
      run_frame("snap2", NINE_OUT);
      tick();

      set_inputs(BASIC_IN, 1'b0);
      hook_act = 2; hook_cyc = 500;
      start_frame();
      run_frame("ignore", BASIC_OUT);
      hook_act = 0;
      idle_err = 0;
      repeat (40) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_err++;
      end
      check("ignore_no_second", idle_err, 0);

      hook_act = 1; hook_cyc = 50;
      start = 1'b1;
      tick();
      run_frame("b2b1", BASIC_OUT);
      tick();
      check("b2b_fall", {31'd0, tx},   0);
      check("b2b_busy", {31'd0, busy}, 1);
      check("b2b_done_width", {31'd0, done}, 0);
      hook_act = 3; hook_cyc = 100;
      run_frame("b2b2", NINE_OUT);
      hook_act = 0;
      tick();
      check("b2b_end_busy", {31'd0, busy}, 0);
      check("b2b_end_done", {31'd0, done}, 0);

      set_inputs(BASIC_IN, 1'b0);
      start_frame();
      repeat (699) tick();
      reset = 1'b0;
      tick();
      check("midrst_tx",   {31'd0, tx},   1);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_done", {31'd0, done}, 0);
      start = 1'b1;
      tick();
      check("rst_start_ign_busy", {31'd0, busy}, 0);
      check("rst_start_ign_tx",   {31'd0, tx},   1);
      start = 1'b0;
      reset = 1'b1;
      tick();
      check("post_rst_idle", {31'd0, busy}, 0);
      start_frame();
      run_frame("after_rst", BASIC_OUT);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
